// File: rtl/move_scheduler.sv
// Step scheduler for a snake game: paces move requests to the datapath at a fixed
// tick rate, filters direction keys (no reversal) and handshakes with move_done.
module move_scheduler #(
  parameter int TICK_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pause,
  input  logic [3:0] buttons,
  input  logic       move_done,
  output logic       move_req,
  output logic [1:0] direction,
  output logic [7:0] moves,
  output logic [2:0] db_state
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNT     = 3'd1,
    PAUSED    = 3'd2,
    REQUEST   = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, cnt_nxt;
  logic [1:0]       pending_dir, pend_nxt;
  logic [1:0]       cand;
  logic             cand_vld;
  logic             commit;

  // Lowest-index pressed key wins; a key opposite to the committed heading is dropped.
  always_comb begin
    cand_vld = |buttons;
    cand     = 2'd3;
    if (buttons[0])      cand = 2'd0;
    else if (buttons[1]) cand = 2'd1;
    else if (buttons[2]) cand = 2'd2;
    pend_nxt = pending_dir;
    if (cand_vld && (cand != (direction ^ 2'b10)))
      pend_nxt = cand;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = counter;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) state_nxt = COUNT;
      end
      COUNT: begin
        if (pause) begin
          state_nxt = PAUSED;
        end else if (counter == TERM) begin
          cnt_nxt   = '0;
          commit    = 1'b1;
          state_nxt = REQUEST;
        end else begin
          cnt_nxt = counter + 1'b1;
        end
      end
      PAUSED: begin
        if (!pause) state_nxt = COUNT;
      end
      REQUEST: begin
        cnt_nxt   = '0;
        state_nxt = move_done ? COUNT : WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_nxt = '0;
        if (move_done) state_nxt = COUNT;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    // Dropping enable aborts whatever is in flight, including a pending terminal count.
    if (!enable && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      commit    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      move_req    <= 1'b0;
      direction   <= 2'b11;
      pending_dir <= 2'b11;
      moves       <= 8'd0;
    end else begin
      state       <= state_nxt;
      counter     <= cnt_nxt;
      move_req    <= (state_nxt == REQUEST);
      pending_dir <= pend_nxt;
      if (commit) begin
        direction <= pending_dir;
        moves     <= moves + 8'd1;
      end
    end
  end

  assign db_state = state;

endmodule

// File: tb/tb_move_scheduler.sv
// Randomized bench for move_scheduler against a cycle-level behavioural model,
// with directed scenarios pinned by hand-computed expectations.
module tb_move_scheduler;

  localparam int TICKS = 4;
  localparam int P_IDLE = 0, P_COUNT = 1, P_PAUSED = 2, P_REQ = 3, P_WAIT = 4;

  logic       clock = 1'b0;
  logic       reset, enable, pause, move_done;
  logic [3:0] buttons;
  logic       move_req;
  logic [1:0] direction;
  logic [7:0] moves;
  logic [2:0] db_state;

  int n_vec = 0;
  int n_err = 0;
  int done_mode = 0;

  // Behavioural model state
  int         m_phase = P_IDLE;
  int         m_cnt   = 0;
  logic [1:0] m_dir   = 2'b11;
  logic [1:0] m_pend  = 2'b11;
  int         m_moves = 0;
  bit         m_req   = 1'b0;

  move_scheduler #(.TICK_CYCLES(TICKS)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .pause     (pause),
    .buttons   (buttons),
    .move_done (move_done),
    .move_req  (move_req),
    .direction (direction),
    .moves     (moves),
    .db_state  (db_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [1:0] old_dir, old_pend;
    int  c;
    bit  found;
    if (reset) begin
      m_phase = P_IDLE; m_cnt = 0; m_dir = 2'b11; m_pend = 2'b11;
      m_moves = 0; m_req = 1'b0;
      return;
    end
    old_dir  = m_dir;
    old_pend = m_pend;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 4; i++)
      if (!found && buttons[i]) begin
        found = 1'b1;
        c = i;
      end
    if (found && (c[1:0] != (old_dir ^ 2'b10))) m_pend = c[1:0];
    m_req = 1'b0;
    if (!enable && m_phase != P_IDLE) begin
      m_phase = P_IDLE;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        P_IDLE:   if (enable) m_phase = P_COUNT;
        P_COUNT:
          if (pause) m_phase = P_PAUSED;
          else if (m_cnt == TICKS - 1) begin
            m_cnt   = 0;
            m_dir   = old_pend;
            m_phase = P_REQ;
            m_moves = (m_moves + 1) % 256;
            m_req   = 1'b1;
          end else m_cnt++;
        P_PAUSED: if (!pause) m_phase = P_COUNT;
        P_REQ:    m_phase = move_done ? P_COUNT : P_WAIT;
        P_WAIT:   if (move_done) m_phase = P_COUNT;
        default:  m_phase = P_IDLE;
      endcase
    end
  endtask

  // Model advances on each edge from the inputs the DUT saw; outputs compared just after.
  always @(posedge clock) begin
    model_step();
    #1;
    chk("move_req", {31'd0, move_req}, {31'd0, m_req});
    chk("direction", {30'd0, direction}, {30'd0, m_dir});
    chk("moves", {24'd0, moves}, m_moves);
    chk("db_state", {29'd0, db_state}, m_phase);
  end

  // Datapath responder: 0 echoes move_done one cycle after move_req, 1 random, 2 low, 3 high.
  initial begin
    bit prev;
    prev = 1'b0;
    move_done = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (done_mode)
        0:       move_done = prev;
        1:       move_done = ($urandom_range(0, 3) == 0);
        2:       move_done = 1'b0;
        default: move_done = 1'b1;
      endcase
      prev = move_req;
    end
  end

  task automatic wait_req(output int n, input int bound);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!move_req && n < bound);
  endtask

  initial begin
    int n, pulses;
    reset = 1'b1; enable = 1'b0; pause = 1'b0; buttons = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_db_state", {29'd0, db_state}, 0);
    chk("rst_direction", {30'd0, direction}, 3);
    chk("rst_moves", {24'd0, moves}, 0);
    chk("rst_move_req", {31'd0, move_req}, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_hold", {29'd0, db_state}, 0);

    enable = 1'b1;
    wait_req(n, 20);
    chk("first_latency", n, 5);
    chk("first_dir", {30'd0, direction}, 3);
    chk("first_moves", {24'd0, moves}, 1);
    chk("model_first_moves", m_moves, 1);
    wait_req(n, 20);
    chk("req_period", n, 6);

    repeat (3) @(negedge clock);
    buttons = 4'b0001;
    @(negedge clock);
    buttons = 4'b0000;
    wait_req(n, 20);
    chk("up_pulse_dir", {30'd0, direction}, 0);
    chk("model_up_dir", {30'd0, m_dir}, 0);

    buttons = 4'b1000;
    wait_req(n, 20);
    chk("right_dir", {30'd0, direction}, 3);
    buttons = 4'b0010;
    wait_req(n, 20);
    chk("reverse_ignored", {30'd0, direction}, 3);
    buttons = 4'b0011;
    wait_req(n, 20);
    buttons = 4'b0000;
    chk("lowest_bit_wins", {30'd0, direction}, 0);
    chk("moves_six", {24'd0, moves}, 6);

    repeat (4) @(negedge clock);
    pause = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (move_req) pulses++;
    end
    chk("paused_db_state", {29'd0, db_state}, 2);
    chk("paused_no_req", pulses, 0);
    done_mode = 2;
    pause = 1'b0;
    wait_req(n, 20);
    chk("resume_latency", n, 3);

    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (move_req) pulses++;
    end
    chk("withheld_pulses", pulses, 0);
    chk("withheld_db_state", {29'd0, db_state}, 4);
    chk("withheld_moves", {24'd0, moves}, 7);
    chk("withheld_dir", {30'd0, direction}, 0);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("wait_rst_db_state", {29'd0, db_state}, 0);
    chk("wait_rst_dir", {30'd0, direction}, 3);
    chk("wait_rst_moves", {24'd0, moves}, 0);
    chk("wait_rst_req", {31'd0, move_req}, 0);

    wait_req(n, 20);
    chk("post_rst_latency", n, 5);
    repeat (3) @(negedge clock);
    chk("wait_db_state", {29'd0, db_state}, 4);
    done_mode = 3;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (db_state != 3'd1 && n < 10);
    chk("done_to_count", {29'd0, db_state}, 1);
    wait_req(n, 20);
    chk("after_done_latency", n, 4);
    done_mode = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      buttons = ($urandom_range(0, 99) < 20) ? 4'($urandom_range(0, 15)) : 4'd0;
      if (!pause) pause = ($urandom_range(0, 39) == 0);
      else        pause = ($urandom_range(0, 3) != 0);
      if (enable) enable = ($urandom_range(0, 149) != 0);
      else        enable = ($urandom_range(0, 4) == 0);
      reset = (cyc > 2000) && ($urandom_range(0, 299) == 0);
      if (cyc % 100 == 0) done_mode = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
    end
    reset = 1'b0; pause = 1'b0; buttons = 4'd0; done_mode = 0;
    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
